// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, line levels and frame-length helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    function automatic int frame_bits(input int data_w, input int stop_bits, input int parity_bits);
        return 1 + data_w + parity_bits + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider; ports clk, rst (async high), clr (sync restart), bit_tick (last clock of each bit)
module uart_baud_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign bit_tick = cnt == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (clr || bit_tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter; clk, rst (async high), tx_valid/tx_ready/tx_data in, tx1 serial out, busy, tx_done; parity bit built only with UART_TX_PARITY_EN
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 2,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx1,
    output logic              busy,
    output logic              tx_done
);

    if (DATA_W < 5 || DATA_W > 9 || CLK_DIV < 1 || CLK_DIV > 65535 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_param: illegal parameter value");
    end

`ifdef UART_TX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t       state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic              handshake, bit_tick, tx1_nxt, done_nxt, par_q;

    assign handshake = tx_valid && tx_ready;

    // The divider restarts on handshake so the start bit gets a full period.
    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (handshake),
        .bit_tick (bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)            par_q <= 1'b0;
        else if (handshake) par_q <= ^tx_data ^ (PARITY_ODD != 0);
`else
    assign par_q = UART_IDLE_LVL;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            tx1     <= UART_IDLE_LVL;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx1     <= tx1_nxt;
            tx_done <= done_nxt;
        end

    // bit_cnt counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE:
                if (handshake) begin
                    state_nxt   = START;
                    shift_nxt   = tx_data;
                    bit_cnt_nxt = '0;
                end
            START:  state_nxt = bit_tick ? DATA : START;
            DATA:
                if (bit_tick) begin
                    shift_nxt   = shift_q >> 1;
                    bit_cnt_nxt = bit_cnt == 4'(DATA_W - 1) ? '0 : bit_cnt + 1'b1;
                    state_nxt   = bit_cnt == 4'(DATA_W - 1) ? AFTER_DATA : DATA;
                end
            PARITY: state_nxt = bit_tick ? STOP : PARITY;
            STOP:
                if (bit_tick) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    state_nxt   = bit_cnt == 4'(STOP_BITS - 1) ? IDLE : STOP;
                end
            default: state_nxt = IDLE;
        endcase
    end

    // tx1 is registered from next-state values so it changes on the same edge as the state.
    always_comb begin
        tx_ready = state == IDLE && !rst;
        busy     = state != IDLE;
        tx1_nxt  = state_nxt == START  ? UART_START_LVL :
                   state_nxt == DATA   ? shift_nxt[0] :
                   state_nxt == PARITY ? par_q : UART_IDLE_LVL;
        done_nxt = state == STOP && state_nxt == IDLE;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next-generation serial TX for the transmitter path. It accepts DATA_W-bit words over a valid/ready handshake and serialises them LSB-first on `tx1` as start bit, data, optional parity and one or two stop bits. It runs from the single system clock with an internal baud divider, so the separate protocol clock input is no longer needed. It sits between the parallel data source and the serial line.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `CLK_DIV`, 2: system clocks per serial bit, legal 1..65535.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_TX_PARITY_EN` is defined.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_valid`  in  1  source has a word on `tx_data`.
- `tx_ready`  out  1  block can accept a word this cycle.
- `tx_data`  in  DATA_W  word to send, sampled on handshake.
- `tx1`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: `tx1`=1, `tx_ready`=0 while `rst` is high, `busy`=0, `tx_done`=0, state IDLE, baud counter 0.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: `tx_ready`=1 and `tx1`=1. A handshake is `tx_valid && tx_ready` at a rising edge.
- On handshake:
  - latch `tx_data` into the shift register;
  - compute parity = ^tx_data (even), inverted when PARITY_ODD=1;
  - clear the baud counter;
  - go to START with `tx1`=0.
- Baud counter counts 0..CLK_DIV-1. `bit_tick` is high when the counter equals CLK_DIV-1, after which the counter wraps to 0. Every state advances only on `bit_tick`.
- DATA: `tx1` = shift_reg[0]. On each `bit_tick` the register shifts right and the 4-bit bit counter increments. After DATA_W bits the FSM goes to PARITY when the macro is on, otherwise to STOP.
- PARITY: `tx1` = latched parity bit.
- STOP: `tx1`=1 for STOP_BITS bit periods. On the final `bit_tick` the FSM returns to IDLE and `tx_done` pulses.
- `busy` = (state != IDLE).
- While busy, `tx_data` and `tx_valid` are ignored. Dropping `tx_valid` mid-frame does not abort the frame.
- Reset mid-frame: the frame is abandoned immediately and `tx1` returns to 1 asynchronously. No `tx_done` pulse.

## Timing
- Handshake at edge k: `tx1` falls at edge k and every bit lasts exactly CLK_DIV cycles.
- Frame length = (1 + DATA_W + P + STOP_BITS) * CLK_DIV cycles, where P = 1 with the macro and 0 without.
- `tx_done` is high in the first IDLE cycle after the frame. `tx_ready` is also high in that cycle.
- A handshake in that cycle starts the next frame at the following edge, so the minimum inter-frame gap is one `clk` of `tx1`=1.
- CLK_DIV=1 is legal: one bit per clock.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state, parity logic and the PARITY_ODD parameter are active, and each frame carries one parity bit after the data.
- `UART_TX_PARITY_EN` undefined: no parity bit. DATA goes directly to STOP, the parity logic is not built, and PARITY_ODD is ignored.

## Structure
- Package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - constants `UART_IDLE_LVL`=1'b1 and `UART_START_LVL`=1'b0;
  - function computing the frame length in bits.
- Sub-module `uart_baud_gen`:
  - inputs `clk`, `rst`, synchronous `clr`;
  - output `bit_tick`;
  - parameter CLK_DIV;
  - reused later by the receiver.

## Test plan
- DATA_W=8, CLK_DIV=4, macro on, even parity; send 0xA5 -> `tx1` bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; 44-cycle frame; `tx_done` pulses at cycle 44.
- Macro on, PARITY_ODD=1; send 0x01 then 0x03 -> parity bits 0 then 1. Same words with PARITY_ODD=0 -> 1 then 0.
- Macro off, STOP_BITS=2, CLK_DIV=2; send 0x3C -> 0,0,0,1,1,1,1,0,0,1,1; 22 cycles; no parity bit.
- `tx_valid` held high with three words -> frames back-to-back with exactly 1 idle cycle between them; `tx_ready` low throughout each frame; data changes while busy are ignored.
- Assert `rst` mid-DATA -> `tx1`=1 and `busy`=0 immediately, no `tx_done`; after release `tx_ready`=1 and the next word transmits cleanly.
- CLK_DIV=1, DATA_W=5, macro off, STOP_BITS=1; send 0x15 -> 0,1,0,1,0,1,1 on consecutive cycles.
